// File: rtl/reg_file_pkg.sv
// Shared definitions for the datapath: ALU mnemonics, register-file geometry
// and the status-flag payload.
package reg_file_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned N_REGS = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SHL = 3'd5,
      OP_SHR = 3'd6,
      OP_MOV = 3'd7
   } op_mne;

   typedef struct packed {
      logic zero;
      logic parity;
      logic odd;
   } flags_t;

endpackage

// File: rtl/flag_reg.sv
// ALU status-flag capture: three flops with a shared enable and sync reset.
module flag_reg
   import reg_file_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   we,
   input  flags_t flags_in,
   output flags_t flags_q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q <= '0;
      end else if (we) begin
         flags_q <= flags_in;
      end
   end

endmodule

// File: rtl/reg_file.sv
// 2**A x W register file with ALU write-back and load write ports, write-through
// read bypass on both read ports, and registered ALU status flags.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int unsigned W = DATA_W,
   parameter int unsigned A = ADDR_W
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [A-1:0] RaddrA,
   input  logic [A-1:0] RaddrB,
   input  logic         WriteEn,
   input  logic [A-1:0] Waddr,
   input  logic [W-1:0] DataIn,
   input  logic         LoadEn,
   input  logic [A-1:0] LoadAddr,
   input  logic [W-1:0] LoadData,
   input  logic         FlagWe,
   input  logic         ZeroIn,
   input  logic         ParityIn,
   input  logic         OddIn,
   output logic [W-1:0] DataOutA,
   output logic [W-1:0] DataOutB,
   output logic         ZeroF,
   output logic         ParityF,
   output logic         OddF
);

   localparam int unsigned DEPTH = 2 ** A;

   logic [W-1:0] regs [DEPTH];
   flags_t       flags_in;
   flags_t       flags_q;

   // Load is written after write-back so it wins on an address collision.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (WriteEn) begin
            regs[Waddr] <= DataIn;
         end
         if (LoadEn) begin
            regs[LoadAddr] <= LoadData;
         end
      end
   end

   // Same priority as the write path; bypass is off while Reset is high.
   always_comb begin
      DataOutA = regs[RaddrA];
      DataOutB = regs[RaddrB];
      if (!Reset) begin
         if (WriteEn && (Waddr == RaddrA)) DataOutA = DataIn;
         if (LoadEn && (LoadAddr == RaddrA)) DataOutA = LoadData;
         if (WriteEn && (Waddr == RaddrB)) DataOutB = DataIn;
         if (LoadEn && (LoadAddr == RaddrB)) DataOutB = LoadData;
      end
   end

   assign flags_in = '{zero: ZeroIn, parity: ParityIn, odd: OddIn};

   flag_reg u_flag_reg (
      .clk      (Clk),
      .reset    (Reset),
      .we       (FlagWe),
      .flags_in (flags_in),
      .flags_q  (flags_q)
   );

   assign ZeroF   = flags_q.zero;
   assign ParityF = flags_q.parity;
   assign OddF    = flags_q.odd;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/load/bypass, collisions, flags,
// reset priority and write resumption after reset.
module tb_reg_file;

   localparam int unsigned W = 8;
   localparam int unsigned A = 3;

   logic         Clk;
   logic         Reset;
   logic [A-1:0] RaddrA, RaddrB;
   logic         WriteEn;
   logic [A-1:0] Waddr;
   logic [W-1:0] DataIn;
   logic         LoadEn;
   logic [A-1:0] LoadAddr;
   logic [W-1:0] LoadData;
   logic         FlagWe;
   logic         ZeroIn, ParityIn, OddIn;
   logic [W-1:0] DataOutA, DataOutB;
   logic         ZeroF, ParityF, OddF;

   int vec_cnt = 0;
   int err_cnt = 0;

   reg_file #(.W(W), .A(A)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .RaddrA   (RaddrA),
      .RaddrB   (RaddrB),
      .WriteEn  (WriteEn),
      .Waddr    (Waddr),
      .DataIn   (DataIn),
      .LoadEn   (LoadEn),
      .LoadAddr (LoadAddr),
      .LoadData (LoadData),
      .FlagWe   (FlagWe),
      .ZeroIn   (ZeroIn),
      .ParityIn (ParityIn),
      .OddIn    (OddIn),
      .DataOutA (DataOutA),
      .DataOutB (DataOutB),
      .ZeroF    (ZeroF),
      .ParityF  (ParityF),
      .OddF     (OddF)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic idle();
      Reset   = 1'b0;
      WriteEn = 1'b0;
      LoadEn  = 1'b0;
      FlagWe  = 1'b0;
   endtask

   // Advance one rising edge and return to the falling edge for stimulus.
   task automatic step();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic check_flags(input string tag, input logic [2:0] exp);
      check(tag, W'({ZeroF, ParityF, OddF}), W'(exp));
   endtask

   initial begin
      idle();
      RaddrA = '0; RaddrB = '0; Waddr = '0; LoadAddr = '0;
      DataIn = '0; LoadData = '0; ZeroIn = 1'b0; ParityIn = 1'b0; OddIn = 1'b0;

      // Single reset cycle then every address reads zero
      @(negedge Clk);
      Reset = 1'b1;
      step();
      idle();
      for (int i = 0; i < 8; i++) begin
         RaddrA = A'(i);
         RaddrB = A'(7 - i);
         #1;
         check($sformatf("rst_a%0d", i), DataOutA, 8'h00);
         check($sformatf("rst_b%0d", 7 - i), DataOutB, 8'h00);
      end
      check_flags("rst_flags", 3'b000);

      // Write with same-cycle bypass on port B, registered read next cycle
      WriteEn = 1'b1; Waddr = 3'd3; DataIn = 8'hA5;
      RaddrA = 3'd0; RaddrB = 3'd3;
      #1;
      check("byp_b3", DataOutB, 8'hA5);
      check("nobyp_a0", DataOutA, 8'h00);
      step();
      idle();
      RaddrA = 3'd3; RaddrB = 3'd3;
      #1;
      check("rd_a3", DataOutA, 8'hA5);
      check("rd_b3_same", DataOutB, 8'hA5);

      // Collision: load wins, both in write and in bypass
      WriteEn = 1'b1; Waddr = 3'd5; DataIn = 8'h11;
      LoadEn = 1'b1; LoadAddr = 3'd5; LoadData = 8'h22;
      RaddrA = 3'd5; RaddrB = 3'd5;
      #1;
      check("coll_byp_a", DataOutA, 8'h22);
      check("coll_byp_b", DataOutB, 8'h22);
      step();
      idle();
      #1;
      check("coll_reg5", DataOutA, 8'h22);

      // Dual write to distinct addresses
      WriteEn = 1'b1; Waddr = 3'd5; DataIn = 8'h11;
      LoadEn = 1'b1; LoadAddr = 3'd6; LoadData = 8'h22;
      RaddrA = 3'd5; RaddrB = 3'd6;
      #1;
      check("dual_byp_a5", DataOutA, 8'h11);
      check("dual_byp_b6", DataOutB, 8'h22);
      step();
      idle();
      #1;
      check("dual_reg5", DataOutA, 8'h11);
      check("dual_reg6", DataOutB, 8'h22);

      // Flags capture, not bypassed, then hold
      FlagWe = 1'b1; ZeroIn = 1'b1; ParityIn = 1'b0; OddIn = 1'b1;
      #1;
      check_flags("flag_nobyp", 3'b000);
      step();
      check_flags("flag_cap", 3'b101);
      FlagWe = 1'b0; ZeroIn = 1'b0; ParityIn = 1'b1; OddIn = 1'b0;
      step();
      check_flags("flag_hold", 3'b101);

      // X addresses with enables low must not disturb state
      idle();
      Waddr = 'x; LoadAddr = 'x; DataIn = 8'hEE; LoadData = 8'hDD;
      RaddrA = 3'd3; RaddrB = 3'd5;
      step();
      #1;
      check("hold_reg3", DataOutA, 8'hA5);
      check("hold_reg5", DataOutB, 8'h11);

      // Reset beats a same-cycle write and suppresses bypass
      WriteEn = 1'b1; Waddr = 3'd7; DataIn = 8'hFF;
      step();
      idle();
      RaddrA = 3'd7;
      #1;
      check("fill_reg7", DataOutA, 8'hFF);
      Reset = 1'b1; WriteEn = 1'b1; Waddr = 3'd7; DataIn = 8'h33;
      FlagWe = 1'b1; ZeroIn = 1'b1; ParityIn = 1'b1; OddIn = 1'b1;
      #1;
      check("rst_nobyp", DataOutA, 8'hFF);
      step();
      #1;
      check("rst_reg7", DataOutA, 8'h00);
      check_flags("rst_flags2", 3'b000);
      RaddrB = 3'd3;
      #1;
      check("rst_reg3", DataOutB, 8'h00);

      // Multi-cycle reset with pending writes, then first write lands
      idle();
      Reset = 1'b1;
      WriteEn = 1'b1; Waddr = 3'd1; DataIn = 8'h77;
      LoadEn = 1'b1; LoadAddr = 3'd4; LoadData = 8'h44;
      repeat (4) step();
      idle();
      WriteEn = 1'b1; Waddr = 3'd2; DataIn = 8'h5A;
      RaddrA = 3'd1; RaddrB = 3'd4;
      #1;
      check("lost_reg1", DataOutA, 8'h00);
      check("lost_reg4", DataOutB, 8'h00);
      step();
      idle();
      RaddrA = 3'd2;
      #1;
      check("post_rst_reg2", DataOutA, 8'h5A);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
